// File: rtl/operand_arbiter_2to1_if.sv
// Handshake bundle between two operand producers, the shared operand arbiter
// and the downstream consumer of the selected word.
interface operand_arbiter_2to1_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic             sel;
    logic [1:0]       grant;

    // Arbiter side: consumes requester words and drives the output stage
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_src, sel, grant
    );

    // Environment side: requesters plus consumer
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_src, sel, grant
    );
endinterface

// File: rtl/operand_arbiter_2to1.sv
// Two-requester round-robin arbiter for a shared operand path: grants are held
// for bursts of up to BURST_LEN words, accepted words land in a one-deep output register.
module operand_arbiter_2to1 #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_arbiter_2to1_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    localparam logic [7:0] L_BURST = 8'(BURST_LEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_sel;
    logic [1:0]       r_grant;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_src;

    logic             w_in_g0;
    logic             w_in_g1;
    logic             w_out_free;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_own_valid;
    logic             w_oth_valid;
    logic             w_xfer;
    logic [7:0]       w_cnt_inc;
    logic             w_burst_end;
    logic [WIDTH-1:0] w_mux_data;
    state_t           w_oth_state;

    assign w_in_g0     = (r_state == ST_G0);
    assign w_in_g1     = (r_state == ST_G1);
    // Readies depend only on registered state and the consumer, never on requester valids
    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign w_ready0    = w_in_g0 && w_out_free;
    assign w_ready1    = w_in_g1 && w_out_free;
    assign w_own_valid = w_in_g1 ? bus.req1_valid : bus.req0_valid;
    assign w_oth_valid = w_in_g1 ? bus.req0_valid : bus.req1_valid;
    assign w_oth_state = w_in_g1 ? ST_G0 : ST_G1;
    assign w_xfer      = (w_ready0 && bus.req0_valid) || (w_ready1 && bus.req1_valid);
    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_burst_end = (w_cnt_inc == L_BURST);
    assign w_mux_data  = r_sel ? bus.req1_data : bus.req0_data;

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_src    = r_out_src;
    assign bus.sel        = r_sel;
    assign bus.grant      = r_grant;

    // Next grant, burst count and round-robin pointer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    w_state_nxt = r_last ? ST_G0 : ST_G1;
                    w_last_nxt  = !r_last;
                    w_cnt_nxt   = 8'd0;
                end else if (bus.req0_valid) begin
                    w_state_nxt = ST_G0;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end else if (bus.req1_valid) begin
                    w_state_nxt = ST_G1;
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_G0, ST_G1: begin
                if (w_xfer) begin
                    if (w_burst_end) begin
                        if (w_oth_valid) begin
                            w_state_nxt = w_oth_state;
                            w_last_nxt  = !w_in_g1;
                            w_cnt_nxt   = 8'd0;
                        end else begin
                            w_cnt_nxt   = 8'd0;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (!w_own_valid) begin
                    if (w_oth_valid) begin
                        w_state_nxt = w_oth_state;
                        w_last_nxt  = !w_in_g1;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end
                end else begin
                    // Granted word is waiting on backpressure: freeze everything
                    w_state_nxt = r_state;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
                w_last_nxt  = 1'b1;
            end
        endcase
    end

    // Arbitration state plus registered decodes of the next grant for sel/grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= (w_state_nxt == ST_G1);
            r_grant <= {(w_state_nxt == ST_G1), (w_state_nxt == ST_G0)};
        end
    end

    // One-deep output stage; only written on an accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_src   <= r_sel;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end
endmodule

// File: tb/tb_operand_arbiter_2to1.sv
// Directed bench for operand_arbiter_2to1: requesters emit numbered words,
// a queue holds the expected output order and is drained as the consumer takes words.
module tb_operand_arbiter_2to1;
    logic clk;
    logic rst_n;

    operand_arbiter_2to1_if #(.WIDTH(32)) bus ();

    operand_arbiter_2to1 #(.WIDTH(32), .BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n0, n1, lim0, lim1;
    logic [32:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_reqs();
        bus.req0_valid = (n0 <= lim0);
        bus.req0_data  = 32'hA000_0000 + 32'(n0);
        bus.req1_valid = (n1 <= lim1);
        bus.req1_data  = 32'hB000_0000 + 32'(n1);
    endtask

    task automatic exp_push(input logic src, input int n);
        sb_q.push_back({src, (src ? 32'hB000_0000 : 32'hA000_0000) + 32'(n)});
    endtask

    // One clock: score any word the consumer takes, advance requesters that handshook
    task automatic cycle();
        logic        h0, h1;
        logic [32:0] e;
        h0 = bus.req0_valid && bus.req0_ready;
        h1 = bus.req1_valid && bus.req1_ready;
        if (bus.out_valid && bus.out_ready) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 33'bx;
            chk("out_data", 64'(bus.out_data), 64'(e[31:0]));
            chk("out_src", 64'(bus.out_src), 64'(e[32]));
        end
        @(posedge clk);
        #1;
        if (h0) n0++;
        if (h1) n1++;
        drive_reqs();
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) cycle();
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    // Assert reset, load requester limits, release rst_n between clock edges
    task automatic do_reset(input int l0, input int l1);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        sb_q.delete();
        n0 = 1; n1 = 1; lim0 = l0; lim1 = l1;
        drive_reqs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        n0 = 1; n1 = 1; lim0 = 8; lim1 = 4;
        drive_reqs();

        // Reset held with both requesters valid, then contention burst pattern
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_sel", 64'(bus.sel), 64'd0);
        chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
        chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        for (int k = 1; k <= 4; k++) exp_push(1'b0, k);
        for (int k = 1; k <= 4; k++) exp_push(1'b1, k);
        for (int k = 5; k <= 8; k++) exp_push(1'b0, k);
        #2;
        rst_n = 1'b1;
        cycle();
        chk("first_grant_g0", 64'(bus.grant), 64'h1);
        for (int k = 2; k <= 14; k++) begin
            cycle();
            if (k <= 13) chk("cont_no_bubble", 64'(bus.out_valid), 64'd1);
            if (k == 5) begin
                chk("cont_grant_g1", 64'(bus.grant), 64'h2);
                chk("cont_sel_g1", 64'(bus.sel), 64'd1);
            end
            if (k == 9) begin
                chk("cont_grant_g0", 64'(bus.grant), 64'h1);
                chk("cont_sel_g0", 64'(bus.sel), 64'd0);
            end
        end
        chk("cont_all_out", 64'(sb_q.size()), 64'd0);

        // Single stream of five words: burst wraps without leaving G0
        do_reset(5, 0);
        for (int k = 1; k <= 5; k++) exp_push(1'b0, k);
        cycle();
        chk("single_grant", 64'(bus.grant), 64'h1);
        for (int k = 2; k <= 7; k++) begin
            cycle();
            if (k <= 6) chk("single_valid", 64'(bus.out_valid), 64'd1);
            if (k == 5) chk("single_wrap_g0", 64'(bus.grant), 64'h1);
        end
        chk("single_all_out", 64'(sb_q.size()), 64'd0);

        // Backpressure with A2 held: readies low, data stable, burst count frozen
        do_reset(5, 1);
        for (int k = 1; k <= 4; k++) exp_push(1'b0, k);
        exp_push(1'b1, 1);
        exp_push(1'b0, 5);
        repeat (3) cycle();
        bus.out_ready = 1'b0;
        #1;
        chk("bp_hold_data", 64'(bus.out_data), 64'hA000_0002);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready0", 64'(bus.req0_ready), 64'd0);
            chk("bp_ready1", 64'(bus.req1_ready), 64'd0);
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_data", 64'(bus.out_data), 64'hA000_0002);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.req0_ready), 64'd1);
        cycle();
        chk("bp_next_word", 64'(bus.out_data), 64'hA000_0003);
        drain("bp_all_out", 20);

        // req0 drops valid after two words while req1 waits
        do_reset(2, 5);
        exp_push(1'b0, 1); exp_push(1'b0, 2);
        for (int k = 1; k <= 4; k++) exp_push(1'b1, k);
        exp_push(1'b0, 3);
        exp_push(1'b1, 5);
        repeat (4) cycle();
        chk("drop_grant_g1", 64'(bus.grant), 64'h2);
        chk("drop_sel", 64'(bus.sel), 64'd1);
        lim0 = 3;
        drive_reqs();
        drain("drop_all_out", 30);

        // Asynchronous reset in the middle of a G1 burst
        do_reset(0, 6);
        exp_push(1'b1, 1);
        repeat (3) cycle();
        chk("mid_in_g1", 64'(bus.grant), 64'h2);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_grant", 64'(bus.grant), 64'd0);
        chk("mid_rst_sel", 64'(bus.sel), 64'd0);
        chk("mid_rst_ready1", 64'(bus.req1_ready), 64'd0);
        sb_q.delete();
        n0 = 1; n1 = 1; lim0 = 2; lim1 = 2;
        drive_reqs();
        exp_push(1'b0, 1); exp_push(1'b0, 2);
        exp_push(1'b1, 1); exp_push(1'b1, 2);
        #2;
        rst_n = 1'b1;
        cycle();
        chk("mid_after_grant", 64'(bus.grant), 64'h1);
        drain("mid_all_out", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
